mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Select-line sequencer and capture stage for the 8:1 multiplexer. It drives S0/S1/S2 to walk through the enabled input channels. After each select change it waits a fixed settle time, then samples the mux output. It assembles the eight samples into a parallel result word, announced by a one-cycle valid pulse. The block sits both upstream of the mux (producing its selects) and downstream of it (consuming `out`).

## Interface
- SETTLE_CYCLES, 2, cycles the select is held stable before sampling; legal range 1..15
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock, synchronous, active-high
- start  input  1  request a scan; honoured only in IDLE
- continuous  input  1  sampled with `start`; when set, the scan repeats until `abort`
- chan_mask  input  8  bit i=1 enables channel i (D0..D7); sampled at each scan start
- abort  input  1  terminate the scan immediately
- mux_out  input  1  output of the 8:1 mux
- S0  output  1  select bit 0 (LSB)
- S1  output  1  select bit 1
- S2  output  1  select bit 2 (MSB)
- busy  output  1  high whenever the state is not IDLE
- result  output  8  bit i = last sampled value of channel i; masked channels read 0
- result_valid  output  1  one-cycle pulse; `result` is updated on the same edge

## Operation
- The FSM has four states: IDLE, SETTLE, SAMPLE and DONE. All outputs are registered.
- IDLE: {S2,S1,S0}=0 and busy=0.
  - If `start`=1, `abort`=0 and `chan_mask`≠0: latch `chan_mask` and `continuous`, clear the shadow word, load the select with the lowest enabled channel, load the settle counter, and go to SETTLE.
  - `start` with `chan_mask`=0 is ignored.
- SETTLE: stay exactly SETTLE_CYCLES cycles, then go to SAMPLE. The select is held constant.
- SAMPLE: stay one cycle and capture `mux_out` into shadow[sel].
  - If a higher enabled channel exists in the latched mask, load the select with the next enabled index (ascending) and go to SETTLE.
  - Otherwise write the shadow word, including this sample, to `result`, assert `result_valid`, and go to DONE.
- DONE: stay one cycle. `result_valid` is high for this cycle only.
  - If the latched `continuous` is 1: re-sample `chan_mask`. If it is nonzero, restart as from IDLE and go directly to SETTLE. If it is zero, go to IDLE.
  - Otherwise go to IDLE.
- `abort` (any non-IDLE state): next state is IDLE.
  - Select returns to 0 and busy drops on the next edge.
  - `result` is unchanged and no `result_valid` is generated. A SAMPLE/DONE transition in the same cycle is discarded.
- `start` while busy is ignored.
- `start` together with `abort` in IDLE: no action.
- Disabled channels are never selected and cost no cycles.

## Timing
- Reset values: state=IDLE, S0=S1=S2=0, busy=0, result=8'h00, result_valid=0, shadow=0, counters=0. Reset takes priority over every other input, including mid-scan.
- With N enabled channels and `start` sampled at edge 0:
  - busy is high from cycle 1.
  - SAMPLE for the k-th channel (k=1..N) occurs in cycle k·(SETTLE_CYCLES+1).
  - `result_valid` is high in cycle N·(SETTLE_CYCLES+1)+1.
  - busy returns low one cycle later (non-continuous).
- Continuous mode: the next scan's first SETTLE begins in the cycle after DONE. `result_valid` pulses are spaced N·(SETTLE_CYCLES+1)+1 cycles apart.
- The select changes only on the edge entering SETTLE (or IDLE). `mux_out` is sampled only in SAMPLE cycles.

## Test plan
- **Full scan.** Bench mux model out=D[sel], D=8'hA6, chan_mask=8'hFF, SETTLE_CYCLES=2, pulse `start`.
  - Select steps 0..7, each held 3 cycles.
  - result=8'hA6 with result_valid in cycle 25; busy low from cycle 26.
- **Sparse mask.** D=8'hFF, chan_mask=8'h81.
  - Select sequence is 0 then 7.
  - result=8'h81 with result_valid in cycle 7.
- **Abort mid-scan.** Full scan with prior result=8'hA6, new D=8'h3C, `abort` asserted in cycle 10.
  - busy=0 and select=0 from cycle 11.
  - No result_valid; result stays 8'hA6.
- **Continuous.** continuous=1, chan_mask=8'h0F, D=8'h05.
  - result_valid pulses at cycles 13 and 26, both with result=8'h05.
  - Set chan_mask=0 before the second DONE: FSM returns to IDLE after that pulse.
- **Ignored requests.**
  - `start` with chan_mask=0: busy stays 0.
  - `start` pulsed during a scan: the scan timing is unchanged.
- **Reset mid-scan.** Assert rst in cycle 5 of a full scan.
  - The next cycle shows all outputs at their reset values.
  - A fresh `start` then completes normally.

Source files
------------

// File: rtl/mux_scan_ctrl_if.sv
// Bus between the scan controller and its environment: scan requests,
// the mux select lines, the mux output and the captured result.
interface mux_scan_ctrl_if;
    logic       start;
    logic       continuous;
    logic [7:0] chan_mask;
    logic       abort;
    logic       mux_out;
    logic       S0;
    logic       S1;
    logic       S2;
    logic       busy;
    logic [7:0] result;
    logic       result_valid;

    // Requester side: issues scans and drives the mux output back in.
    modport master (
        output start, continuous, chan_mask, abort, mux_out,
        input  S0, S1, S2, busy, result, result_valid
    );

    // Controller side.
    modport slave (
        input  start, continuous, chan_mask, abort, mux_out,
        output S0, S1, S2, busy, result, result_valid
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Select-line sequencer and capture stage for an 8:1 mux. Walks the
// enabled channels in ascending order, holds each select for
// SETTLE_CYCLES cycles, samples the mux output for one cycle and
// publishes the assembled word with a one-cycle valid pulse.
module mux_scan_ctrl #(
    parameter logic [3:0] SETTLE_CYCLES = 4'd2
) (
    input  logic            clk,
    input  logic            rst,
    mux_scan_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state_r, state_s;
    logic [2:0] sel_r, sel_s;
    logic [3:0] cnt_r, cnt_s;
    logic [7:0] shadow_r, shadow_s;
    logic [7:0] mask_r, mask_s;
    logic       cont_r, cont_s;
    logic [7:0] result_r, result_s;
    logic       valid_r, valid_s;
    logic       busy_r, busy_s;
    logic [7:0] sample_s;
    logic [3:0] first_s;
    logic [3:0] pick_s;

    // Lowest enabled channel at or above 'from'; bit 3 flags that one exists.
    function automatic logic [3:0] next_chan(input logic [7:0] mask, input logic [3:0] from);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= from)) begin
                r = {1'b1, 3'(i)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Next-state and next-output logic for the scan sequencer.
    always_comb begin
        state_s  = state_r;
        sel_s    = sel_r;
        cnt_s    = cnt_r;
        shadow_s = shadow_r;
        mask_s   = mask_r;
        cont_s   = cont_r;
        result_s = result_r;
        valid_s  = 1'b0;
        sample_s = shadow_r;
        sample_s[sel_r] = bus.mux_out;
        first_s  = next_chan(bus.chan_mask, 4'd0);
        pick_s   = next_chan(mask_r, {1'b0, sel_r} + 4'd1);

        case (state_r)
            IDLE: begin
                sel_s = 3'd0;
                if (bus.start && !bus.abort && (bus.chan_mask != 8'h00)) begin
                    mask_s   = bus.chan_mask;
                    cont_s   = bus.continuous;
                    shadow_s = 8'h00;
                    sel_s    = first_s[2:0];
                    cnt_s    = SETTLE_CYCLES - 4'd1;
                    state_s  = SETTLE;
                end else begin
                    state_s  = IDLE;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    sel_s   = 3'd0;
                    state_s = IDLE;
                end else if (cnt_r == 4'd0) begin
                    state_s = SAMPLE;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            SAMPLE: begin
                if (bus.abort) begin
                    sel_s   = 3'd0;
                    state_s = IDLE;
                end else if (pick_s[3]) begin
                    shadow_s = sample_s;
                    sel_s    = pick_s[2:0];
                    cnt_s    = SETTLE_CYCLES - 4'd1;
                    state_s  = SETTLE;
                end else begin
                    shadow_s = sample_s;
                    result_s = sample_s;
                    valid_s  = 1'b1;
                    state_s  = DONE;
                end
            end
            DONE: begin
                if (bus.abort) begin
                    sel_s   = 3'd0;
                    state_s = IDLE;
                end else if (cont_r && (bus.chan_mask != 8'h00)) begin
                    // Back-to-back rescan: behaves exactly like a start from IDLE.
                    mask_s   = bus.chan_mask;
                    cont_s   = bus.continuous;
                    shadow_s = 8'h00;
                    sel_s    = first_s[2:0];
                    cnt_s    = SETTLE_CYCLES - 4'd1;
                    state_s  = SETTLE;
                end else begin
                    sel_s   = 3'd0;
                    state_s = IDLE;
                end
            end
            default: begin
                sel_s   = 3'd0;
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            sel_r    <= 3'd0;
            cnt_r    <= 4'd0;
            shadow_r <= 8'h00;
            mask_r   <= 8'h00;
            cont_r   <= 1'b0;
            result_r <= 8'h00;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            sel_r    <= sel_s;
            cnt_r    <= cnt_s;
            shadow_r <= shadow_s;
            mask_r   <= mask_s;
            cont_r   <= cont_s;
            result_r <= result_s;
            valid_r  <= valid_s;
            busy_r   <= busy_s;
        end
    end

    assign bus.S0           = sel_r[0];
    assign bus.S1           = sel_r[1];
    assign bus.S2           = sel_r[2];
    assign bus.busy         = busy_r;
    assign bus.result       = result_r;
    assign bus.result_valid = valid_r;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: table of scans plus hand-written
// abort / continuous / reset / ignored-request sequences. Expected results
// go into a scoreboard queue when a scan is launched and are popped by a
// monitor when result_valid is seen.
module tb_mux_scan_ctrl;

    localparam int SC  = 2;
    localparam int PER = SC + 1;

    typedef struct {
        logic [7:0] result;
        int         cycle;
    } exp_t;

    typedef struct {
        logic [7:0] mask;
        logic [7:0] data;
        int         glitch;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    int         checks = 0;
    int         errors = 0;
    int         tcount = 0;
    exp_t       sb[$];
    exp_t       mon_e;
    vec_t       vecs[6];

    mux_scan_ctrl_if bus();

    // Bench model of the 8:1 mux.
    assign bus.mux_out = data[{bus.S2, bus.S1, bus.S0}];

    mux_scan_ctrl #(.SETTLE_CYCLES(4'(SC))) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Free-running edge counter used to time-stamp events.
    always @(posedge clk) tcount <= tcount + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, tcount);
        end
    endtask

    // Scoreboard monitor: every result_valid pulse must match a queued expectation.
    always @(posedge clk) begin
        #1;
        if (bus.result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got result %0h with no scan expected (t=%0d)",
                         bus.result, tcount);
            end else begin
                mon_e = sb.pop_front();
                check("valid_cycle", tcount, mon_e.cycle);
                check("result", bus.result, mon_e.result);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a start request; returns tcount of cycle 1 (first cycle after edge 0).
    task automatic launch(input logic [7:0] m, input logic [7:0] d, input logic c, output int base);
        bus.chan_mask  = m;
        data           = d;
        bus.continuous = c;
        bus.start      = 1'b1;
        tick();
        base      = tcount;
        bus.start = 1'b0;
    endtask

    // One non-continuous scan with select-sequence and busy checks.
    task automatic run_scan(input logic [7:0] m, input logic [7:0] d, input int glitch);
        int   idx[8];
        int   n;
        int   base;
        exp_t e;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                idx[n] = i;
                n++;
            end
        end
        launch(m, d, 1'b0, base);
        e.result = d & m;
        e.cycle  = base + n * PER;
        sb.push_back(e);
        for (int c = 1; c <= n * PER + 1; c++) begin
            if (c > 1) tick();
            bus.start = (c == glitch);
            if (c <= n * PER) begin
                check("select", {29'd0, bus.S2, bus.S1, bus.S0}, idx[(c - 1) / PER]);
            end
            check("busy_scan", bus.busy, 1'b1);
        end
        bus.start = 1'b0;
        tick();
        check("busy_end", bus.busy, 1'b0);
        check("select_end", {29'd0, bus.S2, bus.S1, bus.S0}, 32'd0);
    endtask

    initial begin
        int base;

        vecs[0] = '{mask: 8'hFF, data: 8'hA6, glitch: 0};
        vecs[1] = '{mask: 8'h81, data: 8'hFF, glitch: 0};
        vecs[2] = '{mask: 8'h01, data: 8'h5A, glitch: 0};
        vecs[3] = '{mask: 8'h80, data: 8'h80, glitch: 0};
        vecs[4] = '{mask: 8'hFF, data: 8'h3C, glitch: 5};
        vecs[5] = '{mask: 8'h5A, data: 8'hF0, glitch: 0};

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.continuous = 1'b0;
        bus.chan_mask  = 8'h00;
        bus.abort      = 1'b0;
        data           = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_select", {29'd0, bus.S2, bus.S1, bus.S0}, 32'd0);
        check("rst_result", bus.result, 8'h00);
        check("rst_valid", bus.result_valid, 1'b0);
        tick();

        for (int i = 0; i < 6; i++) begin
            run_scan(vecs[i].mask, vecs[i].data, vecs[i].glitch);
        end

        // Ignored: start with empty mask, and start together with abort.
        bus.chan_mask = 8'h00;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("busy_nomask", bus.busy, 1'b0);
            tick();
        end
        bus.chan_mask = 8'hFF;
        bus.start     = 1'b1;
        bus.abort     = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("busy_start_abort", bus.busy, 1'b0);
        tick();
        check("busy_start_abort2", bus.busy, 1'b0);

        // Abort mid-scan: prior result A6 must survive.
        run_scan(8'hFF, 8'hA6, 0);
        launch(8'hFF, 8'h3C, 1'b0, base);
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) tick();
            bus.abort = (c == 10);
            if (c == 11) begin
                check("abort_busy", bus.busy, 1'b0);
                check("abort_select", {29'd0, bus.S2, bus.S1, bus.S0}, 32'd0);
                check("abort_result", bus.result, 8'hA6);
            end
        end
        bus.abort = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        check("abort_result_hold", bus.result, 8'hA6);
        check("abort_busy_hold", bus.busy, 1'b0);

        // Continuous mode, mask cleared before the second DONE.
        launch(8'h0F, 8'h05, 1'b1, base);
        sb.push_back('{result: 8'h05, cycle: base + 12});
        sb.push_back('{result: 8'h05, cycle: base + 25});
        for (int c = 1; c <= 27; c++) begin
            if (c > 1) tick();
            if (c == 20) bus.chan_mask = 8'h00;
            if (c == 14) check("cont_restart_busy", bus.busy, 1'b1);
            if (c == 27) begin
                check("cont_stop_busy", bus.busy, 1'b0);
                check("cont_stop_select", {29'd0, bus.S2, bus.S1, bus.S0}, 32'd0);
            end
        end
        bus.continuous = 1'b0;
        tick();

        // Reset mid-scan, then a fresh scan.
        launch(8'hFF, 8'hA6, 1'b0, base);
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) tick();
            rst = (c == 5);
            if (c == 6) begin
                check("midrst_busy", bus.busy, 1'b0);
                check("midrst_select", {29'd0, bus.S2, bus.S1, bus.S0}, 32'd0);
                check("midrst_result", bus.result, 8'h00);
                check("midrst_valid", bus.result_valid, 1'b0);
            end
        end
        rst = 1'b0;
        tick();
        run_scan(8'hFF, 8'hA6, 0);

        for (int c = 0; c < 5; c++) tick();
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
